i2c_byte_rx: RTL and testbench

- Clocked I2C byte receiver on the controller side of the bus.
- While enabled by `rx`, it oversamples SCL/SDA, detects START/STOP, and shifts in 8 data bits MSB-first per byte.
- For each byte it presents `data` with a `data_rdy` pulse, then drives the ACK/NACK bit from the `ack` input.
- It connects to the bus through the shared `i2c_if` interface (modport `ctrl_rx`) and is fed and drained by the controller sequencer.

---
 rtl/i2c_pkg.sv | 33 +++
 rtl/i2c_if.sv | 36 +++
 rtl/i2c_bus_sync.sv | 84 ++++++++
 rtl/i2c_byte_rx.sv | 163 ++++++++++++++++
 tb/tb_i2c_byte_rx.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared definitions for the I2C controller receive/transmit
//                path: receiver state encoding, byte geometry and a small
//                shift helper used when assembling bytes MSB-first.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    // Receiver state machine encoding (2 bits wide).
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        DATA       = 2'd2,
        ACK        = 2'd3
    } rx_state_e;

    localparam int BITS_PER_BYTE = 8;

    // Counter wide enough to hold 0..BITS_PER_BYTE inclusive.
    localparam int BIT_CNT_W = $clog2(BITS_PER_BYTE + 1);

    // Shift one bus bit into the LSB end of a byte (bytes arrive MSB first).
    function automatic logic [BITS_PER_BYTE-1:0] shift_in_msb_first(
        input logic [BITS_PER_BYTE-1:0] cur,
        input logic                     bit_in
    );
        return {cur[BITS_PER_BYTE-2:0], bit_in};
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_if.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_if
//  Description : Two-wire I2C bus bundle. SDA is open-drain with a pullup; it
//                is modelled as a wired-AND: every agent only ever asserts a
//                "pull low" request, and the resolved level `sda` reads 1
//                whenever all agents have released the line.
//                Modports:
//                  ctrl_rx : scl (in), sda (in), sda_ctrl_low (out)
//                  tgt     : scl (out), sda_tgt_low (out), sda (in)
//  Revision    : 1.0 - initial release
// ============================================================================
interface i2c_if;

    logic scl;           // clock line, driven by the bus clock owner only
    logic sda_tgt_low;   // remote agent pulling SDA low
    logic sda_ctrl_low;  // this controller pulling SDA low
    logic sda;           // resolved line level

    // Pullup: the line is high unless somebody pulls it low.
    assign sda = ~(sda_tgt_low | sda_ctrl_low);

    modport ctrl_rx (
        input  scl,
        input  sda,
        output sda_ctrl_low
    );

    modport tgt (
        output scl,
        output sda_tgt_low,
        input  sda
    );

endinterface
`default_nettype wire

// File: rtl/i2c_bus_sync.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_bus_sync
//  Description : Input conditioning for I2C SCL/SDA. Synchronises both lines
//                through SYNC_STAGES flops, then detects SCL rising/falling
//                edges and START/STOP conditions against a one-clk delayed
//                copy. Shared by the controller RX and TX paths.
//  Ports       : clk, rstn         - clock, async active-low reset
//                scl_in, sda_in    - raw bus levels
//                sda               - synchronised SDA level
//                scl_rise/scl_fall - one-clk SCL edge strobes
//                start_det         - SDA 1->0 while SCL high
//                stop_det          - SDA 0->1 while SCL high
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;
    logic                   w_scl;
    logic                   w_sda;

    // Chains reset to 1 so an idle (pulled-up) bus raises no spurious edges.
    generate
        if (SYNC_STAGES == 1) begin : g_sync_single
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_scl_sync <= '1;
                    r_sda_sync <= '1;
                end else begin
                    r_scl_sync <= scl_in;
                    r_sda_sync <= sda_in;
                end
            end
        end else begin : g_sync_chain
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_scl_sync <= '1;
                    r_sda_sync <= '1;
                end else begin
                    r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
                    r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
                end
            end
        end
    endgenerate

    assign w_scl = r_scl_sync[SYNC_STAGES-1];
    assign w_sda = r_sda_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
        end else begin
            r_scl_d <= w_scl;
            r_sda_d <= w_sda;
        end
    end

    assign sda      = w_sda;
    assign scl_rise =  w_scl & ~r_scl_d;
    assign scl_fall = ~w_scl &  r_scl_d;
    // SCL must be high in both samples so an SDA change that coincides with
    // an SCL edge is never mistaken for a bus condition.
    assign start_det = w_scl & r_scl_d &  r_sda_d & ~w_sda;
    assign stop_det  = w_scl & r_scl_d & ~r_sda_d &  w_sda;

endmodule
`default_nettype wire

// File: rtl/i2c_byte_rx.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_byte_rx
//  Description : Controller-side I2C byte receiver. While `rx` is high it
//                waits for START, shifts in 8 bits MSB-first on SCL rising
//                edges, publishes the byte with a one-clk `data_rdy` pulse and
//                then drives the ACK/NACK slot from the `ack` input. STOP,
//                repeated START and `rx` deassertion are honoured in every
//                active state.
//  Ports       : clk, rstn  - clock, async active-low reset
//                i2c        - bus (ctrl_rx modport); SCL is never driven
//                rx         - receive enable (level)
//                data       - last complete byte
//                data_rdy   - one-clk strobe when `data` updates
//                ack_en     - high while this block owns the ACK slot
//                ack        - 0 = ACK (pull SDA low), 1 = NACK (release)
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_byte_rx
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    i2c_if.ctrl_rx                   i2c,
    input  logic                     rx,
    output logic [BITS_PER_BYTE-1:0] data,
    output logic                     data_rdy,
    output logic                     ack_en,
    input  logic                     ack
);

    localparam logic [1:0] c_ST_IDLE       = IDLE;
    localparam logic [1:0] c_ST_WAIT_START = WAIT_START;
    localparam logic [1:0] c_ST_DATA       = DATA;
    localparam logic [1:0] c_ST_ACK        = ACK;

    localparam logic [BIT_CNT_W-1:0] c_LAST_BIT = BIT_CNT_W'(BITS_PER_BYTE - 1);

    logic [1:0]               r_state;
    logic [BIT_CNT_W-1:0]     r_bit_cnt;
    logic [BITS_PER_BYTE-1:0] r_shreg;
    logic [BITS_PER_BYTE-1:0] r_data;
    logic                     r_data_rdy;
    logic                     r_ack_en;
    logic                     r_sda_low;
    logic                     r_byte_done;   // 8 bits in, waiting for SCL fall

    logic                     w_sda;
    logic                     w_scl_rise;
    logic                     w_scl_fall;
    logic                     w_start;
    logic                     w_stop;
    logic                     w_active;
    logic [BITS_PER_BYTE-1:0] w_shift;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .clk       (clk),
        .rstn      (rstn),
        .scl_in    (i2c.scl),
        .sda_in    (i2c.sda),
        .sda       (w_sda),
        .scl_rise  (w_scl_rise),
        .scl_fall  (w_scl_fall),
        .start_det (w_start),
        .stop_det  (w_stop)
    );

    assign w_active = (r_state != c_ST_IDLE);
    assign w_shift  = shift_in_msb_first(r_shreg, w_sda);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= c_ST_IDLE;
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
            r_data      <= '0;
            r_data_rdy  <= 1'b0;
            r_ack_en    <= 1'b0;
            r_sda_low   <= 1'b0;
            r_byte_done <= 1'b0;
        end else begin
            r_data_rdy <= 1'b0;

            // Global events first: enable loss beats STOP beats repeated
            // START. Each one abandons any partial byte and releases SDA.
            if (w_active && !rx) begin
                r_state     <= c_ST_IDLE;
                r_bit_cnt   <= '0;
                r_ack_en    <= 1'b0;
                r_sda_low   <= 1'b0;
                r_byte_done <= 1'b0;
            end else if (w_active && w_stop) begin
                r_state     <= c_ST_WAIT_START;
                r_bit_cnt   <= '0;
                r_ack_en    <= 1'b0;
                r_sda_low   <= 1'b0;
                r_byte_done <= 1'b0;
            end else if (w_active && w_start) begin
                r_state     <= c_ST_DATA;
                r_bit_cnt   <= '0;
                r_ack_en    <= 1'b0;
                r_sda_low   <= 1'b0;
                r_byte_done <= 1'b0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        r_sda_low <= 1'b0;
                        if (rx) begin
                            r_state <= c_ST_WAIT_START;
                        end
                    end
                    c_ST_WAIT_START: begin
                        // Only START (handled above) leaves this state.
                        r_sda_low <= 1'b0;
                    end
                    c_ST_DATA: begin
                        if (w_scl_rise && !r_byte_done) begin
                            r_shreg   <= w_shift;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == c_LAST_BIT) begin
                                r_data      <= w_shift;
                                r_data_rdy  <= 1'b1;
                                r_ack_en    <= 1'b1;
                                r_byte_done <= 1'b1;
                            end
                        end else if (w_scl_fall && r_byte_done) begin
                            r_state     <= c_ST_ACK;
                            r_byte_done <= 1'b0;
                            r_sda_low   <= ~ack;
                        end
                    end
                    c_ST_ACK: begin
                        if (w_scl_fall) begin
                            r_state   <= c_ST_DATA;
                            r_bit_cnt <= '0;
                            r_ack_en  <= 1'b0;
                            r_sda_low <= 1'b0;
                        end else begin
                            // Re-sampled every clk so a late change of `ack`
                            // before the SCL rise still lands on the bus.
                            r_sda_low <= ~ack;
                        end
                    end
                    default: begin
                        r_state   <= c_ST_IDLE;
                        r_sda_low <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign i2c.sda_ctrl_low = r_sda_low;
    assign data             = r_data;
    assign data_rdy         = r_data_rdy;
    assign ack_en           = r_ack_en;

endmodule
`default_nettype wire

// File: tb/tb_i2c_byte_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_byte_rx
//  Description : Self-checking bench for i2c_byte_rx. A bus-level target model
//                generates START/STOP/data/ACK slots; expected bytes, ACK
//                levels and output states come from a transaction-level model
//                (queue of completed bytes plus last published value).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_i2c_byte_rx;

    localparam int PH = 6;   // clk cycles per SCL phase

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       rx   = 1'b0;
    logic       ack  = 1'b1;
    logic [7:0] data;
    logic       data_rdy;
    logic       ack_en;

    i2c_if bus ();

    i2c_byte_rx #(
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .i2c      (bus.ctrl_rx),
        .rx       (rx),
        .data     (data),
        .data_rdy (data_rdy),
        .ack_en   (ack_en),
        .ack      (ack)
    );

    always #5 clk = ~clk;

    // ---------------- observation (written only here) ----------------
    int         rdy_cnt   = 0;
    int         rdy_wide  = 0;
    int         drv_cnt   = 0;
    logic       prev_rdy  = 1'b0;
    logic [7:0] obs_q[$];

    always @(negedge clk) begin
        if (data_rdy === 1'b1) begin
            rdy_cnt++;
            obs_q.push_back(data);
            if (prev_rdy) rdy_wide++;
        end
        prev_rdy = (data_rdy === 1'b1);
        if (bus.sda_ctrl_low === 1'b1) drv_cnt++;
    end

    // ---------------- reference model ----------------
    logic [7:0] exp_q[$];
    logic [7:0] exp_last = 8'h00;
    int         n_seen   = 0;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- bus target model ----------------
    task automatic bus_start();   // from idle bus (SCL=1, SDA=1)
        bus.sda_tgt_low = 1'b1; wait_clk(PH);
        bus.scl = 1'b0;         wait_clk(2);
    endtask

    task automatic bus_rstart();  // from SCL low
        bus.sda_tgt_low = 1'b0; wait_clk(PH);
        bus.scl = 1'b1;         wait_clk(PH);
        bus.sda_tgt_low = 1'b1; wait_clk(PH);
        bus.scl = 1'b0;         wait_clk(2);
    endtask

    task automatic bus_stop();    // from SCL low
        bus.sda_tgt_low = 1'b1; wait_clk(PH);
        bus.scl = 1'b1;         wait_clk(PH);
        bus.sda_tgt_low = 1'b0; wait_clk(PH);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        logic [7:0] v;
        v = b;
        for (int i = 0; i < n; i++) begin
            bus.sda_tgt_low = ~v[7];
            v = v << 1;
            wait_clk(PH);
            bus.scl = 1'b1; wait_clk(PH);
            bus.scl = 1'b0; wait_clk(2);
        end
    endtask

    // Full byte plus ACK slot. `en` says whether the receiver should take part.
    task automatic send_byte(input logic [7:0] b, input logic a, input logic en);
        send_bits(b, 8);
        ack = a;
        bus.sda_tgt_low = 1'b0;
        wait_clk(PH);
        bus.scl = 1'b1;
        wait_clk(PH / 2);
        if (en) begin
            check("ack_en_in_slot", ack_en, 1'b1);
            check("ack_sda_level", bus.sda, a);
        end else begin
            check("sda_idle_in_slot", bus.sda, 1'b1);
        end
        wait_clk(PH - PH / 2);
        bus.scl = 1'b0;
        wait_clk(PH);
        check("ack_en_after_slot", ack_en, 1'b0);
        check("sda_released_after_slot", bus.sda_ctrl_low, 1'b0);
        if (en) begin
            exp_q.push_back(b);
            exp_last = b;
        end
    endtask

    task automatic verify(input string tag);
        wait_clk(2);
        check({tag, "_rdy_count"}, rdy_cnt, exp_q.size());
        for (int i = n_seen; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) check({tag, "_byte"}, obs_q[i], exp_q[i]);
        end
        n_seen = exp_q.size();
        check({tag, "_data_hold"}, data, exp_last);
        check({tag, "_sda_released"}, bus.sda_ctrl_low, 1'b0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int         base_drv;
        int         nb;
        logic [7:0] rb;
        logic       ra;

        bus.scl = 1'b1;
        bus.sda_tgt_low = 1'b0;
        wait_clk(4);

        // Reset state
        check("rst_data", data, 8'h00);
        check("rst_data_rdy", data_rdy, 1'b0);
        check("rst_ack_en", ack_en, 1'b0);
        check("rst_sda_low", bus.sda_ctrl_low, 1'b0);
        rstn = 1'b1;
        wait_clk(2);

        // Single byte
        rx = 1'b1; wait_clk(2);
        bus_start();
        send_byte(8'h55, 1'b0, 1'b1);
        bus_stop();
        verify("single");

        // Multi byte, last one NACKed
        bus_start();
        send_byte(8'hAA, 1'b0, 1'b1);
        send_byte(8'h55, 1'b0, 1'b1);
        send_byte(8'hF0, 1'b1, 1'b1);
        bus_stop();
        verify("multi");

        // Disabled: nothing received, SDA never driven
        rx = 1'b0; wait_clk(2);
        base_drv = drv_cnt;
        bus_start();
        send_byte(8'hAA, 1'b0, 1'b0);
        bus_stop();
        verify("disabled");
        check("disabled_no_drive", drv_cnt - base_drv, 0);

        // Abort by rx drop after 4 bits, then a fresh START with 0xF0
        rx = 1'b1; wait_clk(2);
        bus_start();
        send_bits(8'hA5, 4);
        rx = 1'b0; wait_clk(1);
        check("abort_rx_sda", bus.sda_ctrl_low, 1'b0);
        check("abort_rx_ack_en", ack_en, 1'b0);
        rx = 1'b1; wait_clk(2);
        bus_rstart();
        send_byte(8'hF0, 1'b0, 1'b1);
        bus_stop();
        verify("abort_rx");

        // Abort by rx drop while driving ACK: byte already complete
        bus_start();
        send_bits(8'h3C, 8);
        exp_q.push_back(8'h3C);
        exp_last = 8'h3C;
        ack = 1'b0;
        bus.sda_tgt_low = 1'b0;
        wait_clk(PH);
        bus.scl = 1'b1; wait_clk(PH / 2);
        check("abort_ack_driving", bus.sda_ctrl_low, 1'b1);
        rx = 1'b0; wait_clk(1);
        check("abort_ack_released", bus.sda_ctrl_low, 1'b0);
        check("abort_ack_en_clr", ack_en, 1'b0);
        wait_clk(PH);
        bus.scl = 1'b0; wait_clk(2);
        rx = 1'b1; wait_clk(2);
        bus_stop();
        verify("abort_ack");

        // Abort by repeated START after 4 bits
        bus_start();
        send_bits(8'h96, 4);
        bus_rstart();
        send_byte(8'hF0, 1'b0, 1'b1);
        bus_stop();
        verify("abort_rstart");

        // Asynchronous reset while driving ACK
        bus_start();
        send_bits(8'hC3, 8);
        exp_q.push_back(8'hC3);
        ack = 1'b0;
        bus.sda_tgt_low = 1'b0;
        wait_clk(PH);
        bus.scl = 1'b1; wait_clk(PH / 2);
        check("pre_reset_driving", bus.sda_ctrl_low, 1'b1);
        #2 rstn = 1'b0;
        #1;
        exp_last = 8'h00;
        check("mid_rst_data", data, exp_last);
        check("mid_rst_data_rdy", data_rdy, 1'b0);
        check("mid_rst_ack_en", ack_en, 1'b0);
        check("mid_rst_sda", bus.sda_ctrl_low, 1'b0);
        wait_clk(2);
        bus.scl = 1'b0; wait_clk(2);
        rstn = 1'b1; wait_clk(2);
        bus_stop();
        bus_start();
        send_byte(8'h55, 1'b0, 1'b1);
        bus_stop();
        verify("after_reset");

        // Randomised transfers
        for (int t = 0; t < 6; t++) begin
            nb = $urandom_range(1, 3);
            bus_start();
            for (int k = 0; k < nb; k++) begin
                rb = 8'($urandom);
                ra = 1'($urandom_range(0, 1));
                send_byte(rb, ra, 1'b1);
            end
            bus_stop();
            verify("random");
        end

        check("rdy_single_cycle", rdy_wide, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
